// File: rtl/bus_pkg.sv
// Shared FSM state type, error-response default and index-width helper for the bus fabric.
// Pure declarations: no latency, no backpressure.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } fsm_state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // A single-slave fabric still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Base/mask address decoder, lowest matching slave index wins on overlap.
// Combinational, zero latency; no backpressure.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int IDX_W    = idx_width(N_SLAVES)
) (
  input  logic [31:0]            m_addr,
  input  logic [N_SLAVES*32-1:0] slv_base,
  input  logic [N_SLAVES*32-1:0] slv_mask,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx,
  output logic [N_SLAVES-1:0]    sel
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    sel = '0;
    // Scan high to low so the last match written is the lowest index.
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & slv_mask[32*i +: 32]) == slv_base[32*i +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
    if (hit) sel[idx] = 1'b1;
  end

endmodule

// File: rtl/bus_fabric.sv
// Single-master N-slave bus fabric: 2 cycles + slave wait states per access, 1 cycle for unmapped.
// Master holds its request until m_ready; slaves stall via s_ready; BUS_TIMEOUT_EN bounds the stall.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int                      N_SLAVES       = 4,
  parameter int                      DATA_W         = 32,
  parameter logic [N_SLAVES*32-1:0]  SLV_BASE       = {32'h2000_0000, 32'h1000_0000,
                                                       32'h0001_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0]  SLV_MASK       = {32'hFFFF_FF00, 32'hFFFF_0000,
                                                       32'hFFFF_0000, 32'hFFFF_F000},
  parameter int                      TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]       ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_valid,
  input  logic                       m_instr,
  input  logic [31:0]                m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [DATA_W/8-1:0]        m_wstrb,
  output logic                       m_ready,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_err,
  output logic [N_SLAVES-1:0]        s_valid,
  output logic [31:0]                s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [DATA_W/8-1:0]        s_wstrb,
  output logic                       s_instr,
  input  logic [N_SLAVES-1:0]        s_ready,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  output logic [7:0]                 err_count,
  output logic [31:0]                err_addr
);

  localparam int IDX_W = idx_width(N_SLAVES);

  fsm_state_t            state_q, state_d;
  logic [N_SLAVES-1:0]   sel_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic [N_SLAVES-1:0]   dec_sel;
  logic                  sel_ready;
  logic                  timeout_hit;

  bus_addr_decoder #(
    .N_SLAVES (N_SLAVES),
    .IDX_W    (IDX_W)
  ) u_dec (
    .m_addr   (m_addr),
    .slv_base (SLV_BASE),
    .slv_mask (SLV_MASK),
    .hit      (dec_hit),
    .idx      (dec_idx),
    .sel      (dec_sel)
  );

  assign sel_ready = s_ready[idx_q];
  assign s_valid   = (state_q == ACCESS) ? sel_q : '0;
  assign m_ready   = (state_q == RESP) || (state_q == ERR);
  assign m_err     = (state_q == ERR);

`ifdef BUS_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  // Compare against the post-increment value so the limit equals the number of ACCESS cycles.
  assign timeout_hit = ({1'b0, tmo_cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == IDLE && state_d == ACCESS) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ACCESS && !sel_ready) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (m_valid) state_d = dec_hit ? ACCESS : ERR;
      ACCESS:  begin
        if (sel_ready)        state_d = RESP;
        else if (timeout_hit) state_d = ERR;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      idx_q     <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      s_instr   <= 1'b0;
      m_rdata   <= '0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && m_valid && dec_hit) begin
        sel_q   <= dec_sel;
        idx_q   <= dec_idx;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        s_wstrb <= m_wstrb;
        s_instr <= m_instr;
      end
      if (state_q == ACCESS && sel_ready) begin
        m_rdata <= s_rdata[idx_q*DATA_W +: DATA_W];
      end
      // Error bookkeeping lands on ERR entry so it is visible alongside the error response.
      if (state_d == ERR && state_q != ERR) begin
        m_rdata  <= ERR_RDATA;
        err_addr <= (state_q == IDLE) ? m_addr : s_addr;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Bench for bus_fabric: vector table, hand-written corner sequences and a random phase vs. a decode model.
`timescale 1ns/1ps
module tb_bus_fabric;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam logic [31:0] BASE [N] = '{32'h0000_0000, 32'h0001_0000, 32'h1000_0000, 32'h2000_0000};
  localparam logic [31:0] MASK [N] = '{32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FF00};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            m_valid, m_instr;
  logic [31:0]     m_addr;
  logic [DW-1:0]   m_wdata;
  logic [3:0]      m_wstrb;
  logic            m_ready, m_err;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    s_valid, s_ready;
  logic [31:0]     s_addr;
  logic [DW-1:0]   s_wdata;
  logic [3:0]      s_wstrb;
  logic            s_instr;
  logic [N*DW-1:0] s_rdata;
  logic [7:0]      err_count;
  logic [31:0]     err_addr;

  logic            m_valid2, m_ready2, m_err2, s_instr2;
  logic [DW-1:0]   m_rdata2, s_wdata2;
  logic [N-1:0]    s_valid2, s_ready2;
  logic [31:0]     s_addr2, err_addr2;
  logic [3:0]      s_wstrb2;
  logic [7:0]      err_count2;

  bus_fabric #(.N_SLAVES(N), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_instr(s_instr),
    .s_ready(s_ready), .s_rdata(s_rdata), .err_count(err_count), .err_addr(err_addr)
  );

  // Slaves 0 and 1 overlap completely on this instance.
  bus_fabric #(
    .N_SLAVES(N), .DATA_W(DW),
    .SLV_BASE({32'h2000_0000, 32'h1000_0000, 32'h0000_0000, 32'h0000_0000}),
    .SLV_MASK({32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000})
  ) dut_ovl (
    .clk(clk), .rst(rst), .m_valid(m_valid2), .m_instr(m_instr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready2), .m_rdata(m_rdata2), .m_err(m_err2),
    .s_valid(s_valid2), .s_addr(s_addr2), .s_wdata(s_wdata2), .s_wstrb(s_wstrb2), .s_instr(s_instr2),
    .s_ready(s_ready2), .s_rdata(s_rdata), .err_count(err_count2), .err_addr(err_addr2)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        instr;
    int          waitst;
    logic [3:0]  exp_sel;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int          mdl_cnt;
  logic [31:0] mdl_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ref_slave(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & MASK[i]) == BASE[i]) return i;
    return -1;
  endfunction

  task automatic run_xfer(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                          input logic instr, input int waitst, input logic [N-1:0] junk,
                          input logic [N*DW-1:0] rdata, input logic [3:0] exp_sel, input logic exp_err,
                          input int exp_lat, input int exp_sv, input logic [31:0] exp_rdata,
                          input string tag);
    int   cyc, sv_cyc, lat;
    logic sel_ok, stable_ok;
    if (exp_err) begin
      if (mdl_cnt < 255) mdl_cnt++;
      mdl_addr = addr;
    end
    s_rdata = rdata; m_addr = addr; m_wstrb = wstrb; m_wdata = wdata; m_instr = instr;
    s_ready = junk & ~exp_sel;
    m_valid = 1'b1;
    cyc = 0; sv_cyc = 0; lat = -1; sel_ok = 1'b1; stable_ok = 1'b1;
    while (lat < 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (s_valid != '0) begin
        sv_cyc++;
        if (s_valid !== exp_sel) sel_ok = 1'b0;
        if (s_addr !== addr || s_wstrb !== wstrb || s_wdata !== wdata || s_instr !== instr)
          stable_ok = 1'b0;
      end
      if (m_ready === 1'b1) begin
        lat = cyc;
        m_valid = 1'b0;
        check({tag, " m_err"}, 64'(m_err), 64'(exp_err));
        check({tag, " m_rdata"}, 64'(m_rdata), 64'(exp_rdata));
        check({tag, " err_count"}, 64'(err_count), 64'(mdl_cnt));
        check({tag, " err_addr"}, 64'(err_addr), 64'(mdl_addr));
      end
      s_ready = junk & ~exp_sel;
      if (sv_cyc > waitst) s_ready = s_ready | exp_sel;
    end
    s_ready = '0;
    m_valid = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " s_valid cycles"}, 64'(sv_cyc), 64'(exp_sv));
    check({tag, " s_valid onehot/stable"}, {62'd0, sel_ok, stable_ok}, 64'd3);
    if (lat < 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mdl_cnt = 0; mdl_addr = '0;
    end
    @(posedge clk); #1;
  endtask

  vec_t tbl [8];

  initial begin
    logic [N*DW-1:0] tbl_rdata;
    logic [31:0]     a;
    logic [N*DW-1:0] rd;
    int              slv, ws;
    logic            bad;

    tbl[0] = '{32'h0001_0040, 4'b0000, 32'h0,         1'b0, 0, 4'b0010, 1'b0, 2, 32'h1234_5678};
    tbl[1] = '{32'h1000_0004, 4'b0011, 32'hA1B2_C3D4, 1'b0, 3, 4'b0100, 1'b0, 5, 32'h0BAD_0002};
    tbl[2] = '{32'h5000_0000, 4'b0000, 32'h0,         1'b0, 0, 4'b0000, 1'b1, 1, 32'hDEAD_BEEF};
    tbl[3] = '{32'h0000_0FFC, 4'b1111, 32'h55AA_55AA, 1'b0, 1, 4'b0001, 1'b0, 3, 32'hA5A5_0000};
    tbl[4] = '{32'h0000_1000, 4'b0000, 32'h0,         1'b0, 0, 4'b0000, 1'b1, 1, 32'hDEAD_BEEF};
    tbl[5] = '{32'h2000_00FF, 4'b0000, 32'h0,         1'b1, 2, 4'b1000, 1'b0, 4, 32'hCAFE_0003};
    tbl[6] = '{32'h2000_0100, 4'b0000, 32'h0,         1'b0, 0, 4'b0000, 1'b1, 1, 32'hDEAD_BEEF};
    tbl[7] = '{32'h1000_FFFF, 4'b0000, 32'h0,         1'b1, 0, 4'b0100, 1'b0, 2, 32'h0BAD_0002};
    tbl_rdata = {32'hCAFE_0003, 32'h0BAD_0002, 32'h1234_5678, 32'hA5A5_0000};

    rst = 1'b1; m_valid = 1'b0; m_valid2 = 1'b0; m_instr = 1'b0; m_addr = '0; m_wdata = '0;
    m_wstrb = '0; s_ready = '0; s_ready2 = '0; s_rdata = '0;
    mdl_cnt = 0; mdl_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset m_ready", 64'(m_ready), 64'd0);
    check("reset m_err", 64'(m_err), 64'd0);
    check("reset m_rdata", 64'(m_rdata), 64'd0);
    check("reset s_valid", 64'(s_valid), 64'd0);
    check("reset s_addr", 64'(s_addr), 64'd0);
    check("reset err_count", 64'(err_count), 64'd0);
    check("reset err_addr", 64'(err_addr), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset during a stalled access on slave 3.
    m_addr = 32'h2000_0010; m_valid = 1'b1; s_ready = '0;
    @(posedge clk); #1;
    check("stall cycle1 s_valid", 64'(s_valid), 64'h8);
    @(posedge clk); #1;
    check("stall cycle2 s_valid", 64'(s_valid), 64'h8);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst s_valid", 64'(s_valid), 64'd0);
    check("midrst m_ready", 64'(m_ready), 64'd0);
    rst = 1'b0; m_valid = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (m_ready !== 1'b0 || err_count !== 8'd0) bad = 1'b1;
    end
    check("midrst quiet after", 64'(bad), 64'd0);

    for (int i = 0; i < 8; i++)
      run_xfer(tbl[i].addr, tbl[i].wstrb, tbl[i].wdata, tbl[i].instr, tbl[i].waitst, 4'b1111,
               tbl_rdata, tbl[i].exp_sel, tbl[i].exp_err, tbl[i].exp_lat,
               tbl[i].exp_err ? 0 : tbl[i].waitst + 1, tbl[i].exp_rdata, $sformatf("vec%0d", i));

    // Overlapping slaves 0 and 1: only the lower index may be selected.
    m_addr = 32'h0000_0100; s_ready2 = 4'b0011; s_rdata = tbl_rdata; m_valid2 = 1'b1;
    @(posedge clk); #1;
    check("overlap s_valid", 64'(s_valid2), 64'h1);
    @(posedge clk); #1;
    check("overlap m_ready", 64'(m_ready2), 64'd1);
    check("overlap m_rdata", 64'(m_rdata2), 64'hA5A5_0000);
    m_valid2 = 1'b0; s_ready2 = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0:       a = {20'h0, 12'($urandom)};
        1:       a = {16'h0001, 16'($urandom)};
        2:       a = {16'h1000, 16'($urandom)};
        3:       a = {24'h2000_00, 8'($urandom)};
        default: a = $urandom;
      endcase
      rd = {$urandom, $urandom, $urandom, $urandom};
      ws = $urandom_range(0, 3);
      slv = ref_slave(a);
      run_xfer(a, 4'($urandom), $urandom, 1'($urandom), ws, 4'($urandom), rd,
               (slv < 0) ? 4'b0000 : 4'(1 << slv), slv < 0, (slv < 0) ? 1 : ws + 2,
               (slv < 0) ? 0 : ws + 1, (slv < 0) ? 32'hDEAD_BEEF : rd[slv*DW +: DW],
               $sformatf("rnd%0d", i));
    end

`ifdef BUS_TIMEOUT_EN
    run_xfer(32'h2000_0020, 4'b0000, 32'h0, 1'b0, 1000, 4'b0111, tbl_rdata, 4'b1000, 1'b1,
             TMO + 1, TMO, 32'hDEAD_BEEF, "timeout");
    run_xfer(32'h2000_0024, 4'b0000, 32'h0, 1'b0, TMO - 1, 4'b0000, tbl_rdata, 4'b1000, 1'b0,
             TMO + 1, TMO, 32'hCAFE_0003, "ready at limit");
`endif

    for (int i = 0; i < 300; i++)
      run_xfer(32'h5000_0000 | (32'(i) << 4), 4'b0000, 32'h0, 1'b0, 0, 4'b1111, tbl_rdata,
               4'b0000, 1'b1, 1, 0, 32'hDEAD_BEEF, $sformatf("sat%0d", i));
    check("err_count saturated", 64'(err_count), 64'd255);

    run_xfer(32'h0001_0040, 4'b0000, 32'h0, 1'b0, 0, 4'b0000, tbl_rdata, 4'b0010, 1'b0, 2, 1,
             32'h1234_5678, "after sat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
